fft_output_serializer: RTL and testbench

//  Consumer end of the parallel FFT stage interface. Captures the 32 complex outputs of the final

---
 rtl/fft_output_serializer.sv | 91 +++++++++
 tb/tb_fft_output_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_serializer.sv
// Captures one 32-bin FFT frame in parallel and streams it out bin by bin in natural order
// over a valid/ready handshake, accepting the next frame on the final handshake without a gap.
`timescale 1ns/1ps
module fft_output_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int INTEGER     = 4,
  parameter int FRACTION    = 4,
  parameter int BIT_REVERSE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_en,
  output logic                    capture_ready,
  input  logic [32*DATA_WIDTH-1:0] in_real_bus,
  input  logic [32*DATA_WIDTH-1:0] in_imag_bus,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_real,
  output logic [DATA_WIDTH-1:0]   out_imag,
  output logic [4:0]              out_index,
  output logic                    frame_done,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  // The sample format is carried through untouched; only the total width matters here.
  if (INTEGER + FRACTION != DATA_WIDTH) begin : g_format_check
    $error("fft_output_serializer: INTEGER + FRACTION must equal DATA_WIDTH");
  end

  logic [0:0]              state;
  logic [4:0]              idx;
  logic [32*DATA_WIDTH-1:0] buffer_real;
  logic [32*DATA_WIDTH-1:0] buffer_imag;
  logic [4:0]              sel;
  logic                    handshake;
  logic                    last_beat;
  logic                    accept;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  assign handshake     = (state == STREAM) && out_ready;
  assign last_beat     = (idx == 5'd31);
  assign capture_ready = (state == IDLE) || (handshake && last_beat);
  assign accept        = capture_en && capture_ready;
  assign frame_done    = handshake && last_beat;

  // Outputs come only from the registered buffer and index, and read as zero while idle.
  assign sel       = (BIT_REVERSE != 0) ? bitrev5(idx) : idx;
  assign out_valid = (state == STREAM);
  assign out_index = out_valid ? idx : 5'd0;
  assign out_real  = out_valid ? buffer_real[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign out_imag  = out_valid ? buffer_imag[sel*DATA_WIDTH +: DATA_WIDTH] : '0;

  // A capture on the last handshake takes priority so back-to-back frames have no idle gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 5'd0;
      buffer_real <= '0;
      buffer_imag <= '0;
    end else if (accept) begin
      state       <= STREAM;
      idx         <= 5'd0;
      buffer_real <= in_real_bus;
      buffer_imag <= in_imag_bus;
    end else if (handshake) begin
      idx <= idx + 5'd1;
      if (last_beat) begin
        state <= IDLE;
      end
    end
  end

  // A rejected capture wins over a simultaneous clear so no overrun event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (capture_en && !capture_ready) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench for fft_output_serializer: the driver queues expected beats, a negedge
// monitor pops and compares every handshake.
`timescale 1ns/1ps
module tb_fft_output_serializer;

  logic         clk;
  logic         reset;
  logic         capture_en;
  logic         capture_ready;
  logic [255:0] in_real_bus;
  logic [255:0] in_imag_bus;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_real;
  logic [7:0]   out_imag;
  logic [4:0]   out_index;
  logic         frame_done;
  logic         overrun;
  logic         clr_overrun;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] re;
    logic [7:0] im;
    logic       done;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Real part seen on beat n when real[k]=k, i.e. the 5-bit reversal of n, written out by hand.
  int rev_tab[32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                      1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  fft_output_serializer #(
    .DATA_WIDTH(8), .INTEGER(4), .FRACTION(4), .BIT_REVERSE(1)
  ) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .capture_ready(capture_ready),
    .in_real_bus(in_real_bus), .in_imag_bus(in_imag_bus), .out_valid(out_valid),
    .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .frame_done(frame_done), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic load_buses(input int base);
    for (int k = 0; k < 32; k++) begin
      in_real_bus[k*8 +: 8] = 8'(base + k);
      in_imag_bus[k*8 +: 8] = 8'(-(base + k));
    end
  endtask

  task automatic load_const(input logic [7:0] v);
    for (int k = 0; k < 32; k++) begin
      in_real_bus[k*8 +: 8] = v;
      in_imag_bus[k*8 +: 8] = v;
    end
  endtask

  task automatic push_expected(input int base);
    beat_t b;
    for (int n = 0; n < 32; n++) begin
      b.idx  = 5'(n);
      b.re   = 8'(base + rev_tab[n]);
      b.im   = 8'(-(base + rev_tab[n]));
      b.done = (n == 31);
      exp_q.push_back(b);
    end
  endtask

  // Issue a frame at the next edge; returns at posedge+1 of the bin-0 cycle.
  task automatic apply_stimulus(input int base);
    load_buses(base);
    push_expected(base);
    capture_en = 1'b1;
    @(posedge clk); #1;
    capture_en = 1'b0;
  endtask

  task automatic wait_drain(output int cycles, output int drops);
    cycles = 0;
    drops  = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      @(negedge clk); #1;
      cycles++;
      if (!out_valid) drops++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: index %0d, expected no beat", out_index);
        end else begin
          e = exp_q.pop_front();
          check_output("beat_index", 32'(out_index), 32'(e.idx));
          check_output("beat_real", 32'(out_real), 32'(e.re));
          check_output("beat_imag", 32'(out_imag), 32'(e.im));
          check_output("beat_frame_done", 32'(frame_done), 32'(e.done));
        end
      end else begin
        check_output("frame_done_no_handshake", 32'(frame_done), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int drops;

    reset       = 1'b1;
    capture_en  = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    in_real_bus = '0;
    in_imag_bus = '0;

    // Reset state, held and after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_real", 32'(out_real), 32'd0);
    check_output("rst_out_imag", 32'(out_imag), 32'd0);
    check_output("rst_out_index", 32'(out_index), 32'd0);
    check_output("rst_frame_done", 32'(frame_done), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_capture_ready", 32'(capture_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("rel_out_valid", 32'(out_valid), 32'd0);
    check_output("rel_capture_ready", 32'(capture_ready), 32'd1);
    check_output("rel_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;

    $display("[TB] frame with continuous out_ready");
    out_ready = 1'b1;
    apply_stimulus(0);
    wait_drain(cycles, drops);
    check_output("frame_cycles", 32'(cycles), 32'd32);
    check_output("frame_valid_drops", 32'(drops), 32'd0);
    check_output("idle_after_frame", 32'(out_valid), 32'd0);

    $display("[TB] backpressure at beat 5");
    apply_stimulus(0);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("hold_valid", 32'(out_valid), 32'd1);
      check_output("hold_index", 32'(out_index), 32'd5);
      check_output("hold_real", 32'(out_real), 32'd20);
      check_output("hold_imag", 32'(out_imag), 32'hEC);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("resume_index", 32'(out_index), 32'd6);
    check_output("resume_real", 32'(out_real), 32'd12);
    wait_drain(cycles, drops);

    $display("[TB] rejected capture at beat 10");
    apply_stimulus(0);
    repeat (10) @(posedge clk);
    #1;
    check_output("busy_capture_ready", 32'(capture_ready), 32'd0);
    load_const(8'h7F);
    capture_en = 1'b1;
    @(posedge clk); #1;
    capture_en = 1'b0;
    check_output("overrun_set", 32'(overrun), 32'd1);
    wait_drain(cycles, drops);
    check_output("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    check_output("overrun_cleared", 32'(overrun), 32'd0);

    $display("[TB] back-to-back frames");
    apply_stimulus(0);
    repeat (31) @(posedge clk);
    #1;
    check_output("b2b_last_index", 32'(out_index), 32'd31);
    check_output("b2b_capture_ready", 32'(capture_ready), 32'd1);
    apply_stimulus(32);
    check_output("b2b_valid", 32'(out_valid), 32'd1);
    check_output("b2b_index", 32'(out_index), 32'd0);
    check_output("b2b_real", 32'(out_real), 32'd32);
    check_output("b2b_overrun", 32'(overrun), 32'd0);
    wait_drain(cycles, drops);
    check_output("b2b_cycles", 32'(cycles), 32'd32);
    check_output("b2b_valid_drops", 32'(drops), 32'd0);
    check_output("b2b_overrun_end", 32'(overrun), 32'd0);

    $display("[TB] asynchronous reset mid-frame");
    apply_stimulus(64);
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_output("arst_out_valid", 32'(out_valid), 32'd0);
    check_output("arst_out_real", 32'(out_real), 32'd0);
    check_output("arst_out_imag", 32'(out_imag), 32'd0);
    check_output("arst_out_index", 32'(out_index), 32'd0);
    check_output("arst_frame_done", 32'(frame_done), 32'd0);
    check_output("arst_capture_ready", 32'(capture_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("arst_rel_capture_ready", 32'(capture_ready), 32'd1);
    check_output("arst_rel_out_valid", 32'(out_valid), 32'd0);
    apply_stimulus(0);
    check_output("arst_new_index", 32'(out_index), 32'd0);
    wait_drain(cycles, drops);
    check_output("arst_new_cycles", 32'(cycles), 32'd32);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
